// File: rtl/lebug_pkg.sv
// Shared types for the vector packer: per-chain firmware mode and its decode.
package lebug_pkg;

    typedef enum logic [1:0] {
        PASS = 2'd0,
        PACK = 2'd1,
        DROP = 2'd2
    } pack_mode_t;

    // Only the low two bits of a firmware mode byte are meaningful; 2 and 3 both drop.
    function automatic pack_mode_t decode_mode(input logic [1:0] mode_bits);
        case (mode_bits)
            2'd0:    return PASS;
            2'd1:    return PACK;
            default: return DROP;
        endcase
    endfunction

endpackage

// File: rtl/packer_out_fifo.sv
// Output FIFO of the vector packer: two ordered push ports (a before b), one pop port.
module packer_out_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             push_b,
    input  logic [WIDTH-1:0] data_b,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             lost_b
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             acc_a;
    logic             acc_b;
    logic             do_pop;

    // Room is judged on the occupancy before this cycle's pop.
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign acc_a   = push_a && !full;
    assign acc_b   = push_b && ((count + (AW+1)'(acc_a)) < (AW+1)'(DEPTH));
    assign lost_b  = push_b && !acc_b;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (acc_a) mem[wr_ptr] <= data_a;
        if (acc_b) mem[wr_ptr + AW'(acc_a)] <= data_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(acc_a) + AW'(acc_b);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(acc_a) + (AW+1)'(acc_b) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/vector_packer.sv
// Trace-path packer: per-chain pass / pack-element-0 / drop, feeding a 2-port output FIFO.
module vector_packer
    import lebug_pkg::*;
#(
    parameter int unsigned N                  = 8,
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned MAX_CHAINS         = 4,
    parameter logic [7:0]  PERSONAL_CONFIG_ID = 8'd0,
    parameter int unsigned FIFO_DEPTH         = 4,
    parameter logic [MAX_CHAINS-1:0][7:0] INITIAL_FIRMWARE_MODE = '0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 tracing,
    input  logic                                 valid_in,
    input  logic                                 eof_in,
    input  logic [$clog2(MAX_CHAINS)-1:0]        chainId_in,
    input  logic [7:0]                           configId,
    input  logic [7:0]                           configData,
    input  logic [N-1:0][DATA_WIDTH-1:0]         vector_in,
    output logic [N-1:0][DATA_WIDTH-1:0]         vector_out,
    output logic [$clog2(MAX_CHAINS)-1:0]        chainId_out,
    output logic                                 valid_out,
    output logic                                 eof_out,
    output logic                                 overflow
);
    localparam int unsigned CW = $clog2(MAX_CHAINS);
    localparam int unsigned KW = $clog2(N) + 1;

    typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;
    typedef struct packed {
        vec_t          vector;
        logic [CW-1:0] chain;
        logic          eof;
    } trace_word_t;
    localparam int unsigned WW = $bits(trace_word_t);

    logic [MAX_CHAINS-1:0][7:0] firmware_mode;
    logic [CW-1:0]              cfg_ptr;

    logic          s1_valid;
    pack_mode_t    s1_mode;
    vec_t          s1_vector;
    logic [CW-1:0] s1_chain;
    logic          s1_eof;

    vec_t          pbuf, pbuf_n;
    logic [KW-1:0] pcount, pcount_n;
    logic [CW-1:0] pchain, pchain_n;

    trace_word_t   flush_word, pack_word, pass_word, data_a, data_b;
    logic          push_a, push_b, restart, complete;
    logic [KW-1:0] base;

    logic [WW-1:0] fifo_rd;
    trace_word_t   head;
    logic          fifo_full, fifo_empty, fifo_lost_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            firmware_mode <= INITIAL_FIRMWARE_MODE;
            cfg_ptr       <= '0;
        end else if (configId == PERSONAL_CONFIG_ID) begin
            firmware_mode[cfg_ptr] <= configData;
            cfg_ptr <= (cfg_ptr == CW'(MAX_CHAINS - 1)) ? '0 : cfg_ptr + 1'b1;
        end else begin
            cfg_ptr <= '0;
        end
    end

    // Mode is decoded at acceptance, before any config write landing on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_mode   <= PASS;
            s1_vector <= '0;
            s1_chain  <= '0;
            s1_eof    <= 1'b0;
        end else begin
            s1_valid <= valid_in && tracing;
            if (valid_in && tracing) begin
                s1_mode   <= decode_mode(firmware_mode[chainId_in][1:0]);
                s1_vector <= vector_in;
                s1_chain  <= chainId_in;
                s1_eof    <= eof_in;
            end
        end
    end

    always_comb begin
        restart  = (pcount != '0) &&
                   ((s1_mode == PASS) || ((s1_mode == PACK) && (s1_chain != pchain)));
        base     = restart ? '0 : pcount;
        complete = (base == KW'(N - 1)) || s1_eof;

        flush_word        = '0;
        flush_word.chain  = pchain;
        pack_word         = '0;
        pack_word.chain   = s1_chain;
        pack_word.eof     = s1_eof;
        // Slots beyond the fill level read as zero, so the buffer never needs clearing.
        for (int unsigned i = 0; i < N; i++) begin
            if (KW'(i) < pcount) flush_word.vector[i] = pbuf[i];
            if (KW'(i) < base)
                pack_word.vector[i] = pbuf[i];
            else if (KW'(i) == base)
                pack_word.vector[i] = s1_vector[0];
        end
        pass_word.vector = s1_vector;
        pass_word.chain  = s1_chain;
        pass_word.eof    = s1_eof;

        pbuf_n   = pbuf;
        pcount_n = pcount;
        pchain_n = pchain;
        push_a   = 1'b0;
        push_b   = 1'b0;
        data_a   = flush_word;
        data_b   = pass_word;

        if (s1_valid) begin
            case (s1_mode)
                PASS: begin
                    pcount_n = '0;
                    push_a   = 1'b1;
                    if (restart) push_b = 1'b1;
                    else         data_a = pass_word;
                end
                PACK: begin
                    for (int unsigned i = 0; i < N; i++)
                        if (KW'(i) == base) pbuf_n[i] = s1_vector[0];
                    pchain_n = s1_chain;
                    pcount_n = complete ? '0 : base + KW'(1);
                    if (restart) begin
                        push_a = 1'b1;
                        push_b = complete;
                        data_b = pack_word;
                    end else if (complete) begin
                        push_a = 1'b1;
                        data_a = pack_word;
                    end
                end
                default: begin
                    if (s1_eof && (pcount != '0)) begin
                        push_a     = 1'b1;
                        data_a.eof = 1'b1;
                        pcount_n   = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pbuf   <= '0;
            pcount <= '0;
            pchain <= '0;
        end else begin
            pbuf   <= pbuf_n;
            pcount <= pcount_n;
            pchain <= pchain_n;
        end
    end

    packer_out_fifo #(
        .WIDTH(WW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_a  (push_a),
        .data_a  (data_a),
        .push_b  (push_b),
        .data_b  (data_b),
        .pop     (!fifo_empty),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .lost_b  (fifo_lost_b)
    );

    assign head = trace_word_t'(fifo_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vector_out  <= '0;
            chainId_out <= '0;
            valid_out   <= 1'b0;
            eof_out     <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            valid_out <= !fifo_empty;
            if (!fifo_empty) begin
                vector_out  <= head.vector;
                chainId_out <= head.chain;
                eof_out     <= head.eof;
            end else begin
                eof_out <= 1'b0;
            end
            if ((push_a && fifo_full) || fifo_lost_b) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vector_packer.sv
// Self-checking bench for vector_packer: queue-based reference model plus directed literal checks.
module tb_vector_packer;
    localparam int N     = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int VW    = N * DW;

    typedef logic [N-1:0][DW-1:0] vec_t;
    typedef struct packed { vec_t v; logic [1:0] c; logic e; } w_t;
    typedef struct { bit v; int mode; vec_t vec; logic [1:0] ch; logic eof; } s1_t;

    logic       clk = 1'b0, rst_n = 1'b0, tracing = 1'b0, valid_in = 1'b0, eof_in = 1'b0;
    logic [1:0] chainId_in = '0;
    logic [7:0] configId = 8'hFF, configData = '0;
    vec_t       vector_in = '0;
    vec_t       vector_out;
    logic [1:0] chainId_out;
    logic       valid_out, eof_out, overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vector_packer #(
        .N(N), .DATA_WIDTH(DW), .MAX_CHAINS(4), .PERSONAL_CONFIG_ID(8'd0),
        .FIFO_DEPTH(DEPTH), .INITIAL_FIRMWARE_MODE('0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tracing(tracing), .valid_in(valid_in), .eof_in(eof_in),
        .chainId_in(chainId_in), .configId(configId), .configData(configData),
        .vector_in(vector_in), .vector_out(vector_out), .chainId_out(chainId_out),
        .valid_out(valid_out), .eof_out(eof_out), .overflow(overflow)
    );

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  fw [4];
    int          cptr;
    s1_t         m_s1;
    logic [31:0] pk [$];
    logic [1:0]  pk_ch;
    w_t          fq [$];
    int          room;
    w_t          m_head;
    logic        m_valid, m_eof, m_ovf;
    vec_t        m_vec;
    logic [1:0]  m_ch;

    function automatic w_t pad_word(input logic [1:0] ch, input logic e);
        w_t w;
        w.v = '0;
        for (int i = 0; i < pk.size(); i++) w.v[i] = pk[i];
        w.c = ch;
        w.e = e;
        return w;
    endfunction

    task automatic push_w(input w_t w);
        if (room < DEPTH) begin
            fq.push_back(w);
            room++;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic model_s1();
        w_t w;
        case (m_s1.mode)
            0: begin
                if (pk.size() > 0) push_w(pad_word(pk_ch, 1'b0));
                pk.delete();
                w.v = m_s1.vec; w.c = m_s1.ch; w.e = m_s1.eof;
                push_w(w);
            end
            1: begin
                if (pk.size() > 0 && pk_ch != m_s1.ch) begin
                    push_w(pad_word(pk_ch, 1'b0));
                    pk.delete();
                end
                pk.push_back(m_s1.vec[0]);
                pk_ch = m_s1.ch;
                if (pk.size() == N || m_s1.eof) begin
                    push_w(pad_word(pk_ch, m_s1.eof));
                    pk.delete();
                end
            end
            default: begin
                if (m_s1.eof && pk.size() > 0) begin
                    push_w(pad_word(pk_ch, 1'b1));
                    pk.delete();
                end
            end
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) fw[i] = 8'd0;
            cptr = 0; m_s1.v = 0; pk.delete(); fq.delete(); pk_ch = '0;
            m_valid = 0; m_eof = 0; m_ovf = 0; m_vec = '0; m_ch = '0;
        end else begin
            room = fq.size();
            if (fq.size() > 0) begin
                m_head  = fq.pop_front();
                m_valid = 1; m_vec = m_head.v; m_ch = m_head.c; m_eof = m_head.e;
            end else begin
                m_valid = 0;
            end
            if (m_s1.v) model_s1();
            m_s1.v = valid_in && tracing;
            if (m_s1.v) begin
                m_s1.mode = (fw[chainId_in][1:0] == 2'd0) ? 0 : (fw[chainId_in][1:0] == 2'd1) ? 1 : 2;
                m_s1.vec  = vector_in;
                m_s1.ch   = chainId_in;
                m_s1.eof  = eof_in;
            end
            if (configId == 8'd0) begin
                fw[cptr] = configData;
                cptr = (cptr + 1) % 4;
            end else begin
                cptr = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("valid_out", valid_out, m_valid);
        chk("overflow", overflow, m_ovf);
        chk("vector_out", vector_out, m_vec);
        chk("chainId_out", chainId_out, m_ch);
        if (m_valid) chk("eof_out", eof_out, m_eof);
    end

    // ---------------- stimulus helpers ----------------
    task automatic put(input logic v, input logic [1:0] ch, input vec_t vec, input logic e);
        @(negedge clk); #1;
        valid_in = v; tracing = 1'b1; chainId_in = ch; vector_in = vec; eof_in = e; configId = 8'hFF;
    endtask

    task automatic idle();
        put(1'b0, 2'd0, '0, 1'b0);
    endtask

    task automatic cfg4(input logic [3:0][7:0] m);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            valid_in = 1'b0; configId = 8'd0; configData = m[i];
        end
        idle();
    endtask

    function automatic vec_t seq_vec(input int start, input int n);
        vec_t v = '0;
        for (int i = 0; i < n; i++) v[i] = 32'(start + i);
        return v;
    endfunction

    function automatic vec_t scalar(input int x);
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = $urandom;
        v[0] = 32'(x);
        return v;
    endfunction

    task automatic expect_word(input string nm, input vec_t v, input logic [1:0] c, input logic e,
                               input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (valid_out) begin
                chk({nm, "_vec"}, vector_out, v);
                chk({nm, "_chain"}, chainId_out, c);
                chk({nm, "_eof"}, eof_out, e);
                return;
            end
        end
        chk({nm, "_timeout"}, valid_out, 1'b1);
    endtask

    int nvalid;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_vector", vector_out, '0);
        chk("rst_overflow", overflow, 1'b0);
        @(negedge clk); #1 rst_n = 1'b1;
        idle();
        // chain0 PASS, chain1 PACK, chain2 PACK, chain3 DROP
        cfg4({8'd3, 8'd1, 8'd1, 8'd0});

        // 1: PASS latency and data
        put(1'b1, 2'd0, seq_vec(1, 8), 1'b0);
        idle();
        chk("pass_lat0", valid_out, 1'b0);
        @(posedge clk); #1 chk("pass_lat1", valid_out, 1'b0);
        @(posedge clk); #1 chk("pass_lat2", valid_out, 1'b1);
        chk("pass_vec", vector_out, seq_vec(1, 8));
        chk("pass_chain", chainId_out, 2'd0);

        // 2: eight packed scalars form one word
        for (int i = 0; i < 8; i++) put(1'b1, 2'd1, scalar(10 + i), 1'b0);
        idle();
        expect_word("pack8", seq_vec(10, 8), 2'd1, 1'b0, 6);

        // 3: eof flush of a partial pack
        put(1'b1, 2'd1, scalar(5), 1'b0);
        put(1'b1, 2'd1, scalar(6), 1'b0);
        put(1'b1, 2'd1, scalar(7), 1'b1);
        idle();
        expect_word("flush", seq_vec(5, 3), 2'd1, 1'b1, 6);

        // 4: partial pack displaced by a PASS vector
        put(1'b1, 2'd1, scalar(20), 1'b0);
        put(1'b1, 2'd1, scalar(21), 1'b0);
        put(1'b1, 2'd0, seq_vec(100, 8), 1'b0);
        idle();
        expect_word("coll_pad", seq_vec(20, 2), 2'd1, 1'b0, 6);
        expect_word("coll_vec", seq_vec(100, 8), 2'd0, 1'b0, 1);
        repeat (3) idle();
        chk("no_ovf_yet", overflow, 1'b0);

        // 5: sustained collisions overflow the 2-deep FIFO
        for (int i = 0; i < 6; i++) begin
            put(1'b1, 2'd1, scalar(200 + i), 1'b0);
            put(1'b1, 2'd0, seq_vec(300 + 8 * i, 8), 1'b0);
        end
        repeat (6) idle();
        chk("ovf_set", overflow, 1'b1);

        // 6: DROP chain produces nothing; reset mid-pack clears everything
        cfg4({8'd1, 8'd0, 8'd1, 8'd2});
        put(1'b1, 2'd0, seq_vec(50, 8), 1'b1);
        idle();
        nvalid = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (valid_out) nvalid++;
        end
        chk("drop_silent", nvalid, 0);
        put(1'b1, 2'd1, scalar(30), 1'b0);
        put(1'b1, 2'd1, scalar(31), 1'b0);
        idle();
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", valid_out, 1'b0);
        chk("mid_rst_vector", vector_out, '0);
        chk("mid_rst_chain", chainId_out, 2'd0);
        chk("mid_rst_ovf", overflow, 1'b0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        cfg4({8'd0, 8'd0, 8'd1, 8'd0});
        put(1'b1, 2'd1, scalar(40), 1'b1);
        idle();
        expect_word("post_rst_pack", seq_vec(40, 1), 2'd1, 1'b1, 6);

        // randomized traffic against the model
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk); #1;
            if (cyc == 800) rst_n = 1'b0;
            if (cyc == 803) rst_n = 1'b1;
            tracing    = ($urandom_range(0, 7) != 0);
            valid_in   = ($urandom_range(0, 3) != 0);
            eof_in     = ($urandom_range(0, 7) == 0);
            chainId_in = 2'($urandom_range(0, 3));
            for (int i = 0; i < N; i++) vector_in[i] = $urandom;
            configId   = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            configData = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
        end
        repeat (10) idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
